// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode decoupling buffer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential PC of an entry; carry out of bit 31 is discarded.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for fetch_buffer: synchronous write port, asynchronous read port.
module fetch_buffer_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  fetch_entry_t         wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output fetch_entry_t         rdata_o
);

    fetch_entry_t mem_q [DEPTH];

    // Storage write; contents are not reset because d_valid gates their use.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode FIFO with PC back-pressure and flush shadow.
// Optional same-cycle bypass when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int SKID         = 2,
    parameter int FLUSH_SHADOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        flush,
    output logic        stall,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc_plus4,
    output logic [31:0] d_instr,
    output logic        overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SH_W  = (FLUSH_SHADOW > 0) ? $clog2(FLUSH_SHADOW + 1) : 1;

    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - SKID);
    localparam logic [SH_W-1:0]  SH_LOAD   = SH_W'(FLUSH_SHADOW);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SH_W-1:0]  shadow_q, shadow_d;
    logic             overflow_q, overflow_d;

    logic         push_req_s;
    logic         empty_s;
    logic         full_s;
    logic         bypass_s;
    logic         pop_s;
    logic         rd_en_s;
    logic         wr_en_s;
    fetch_entry_t wr_entry_s;
    fetch_entry_t rd_entry_s;

    assign push_req_s = f_valid & ~flush & (shadow_q == {SH_W{1'b0}});
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    assign full_s     = (count_q == FULL_LVL);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass_s   = empty_s & push_req_s;
    assign d_valid    = ~empty_s | bypass_s;
    assign d_pc       = bypass_s ? f_pc    : rd_entry_s.pc;
    assign d_instr    = bypass_s ? f_instr : rd_entry_s.instr;
`else
    assign bypass_s   = 1'b0;
    assign d_valid    = ~empty_s;
    assign d_pc       = rd_entry_s.pc;
    assign d_instr    = rd_entry_s.instr;
`endif

    assign d_pc_plus4 = pc_plus4(d_pc);
    assign stall      = (count_q >= STALL_LVL);
    assign overflow   = overflow_q;

    // A bypassed entry taken by decode never touches storage.
    assign pop_s      = d_valid & d_ready & ~flush;
    assign rd_en_s    = pop_s & ~empty_s;
    assign wr_en_s    = push_req_s & (~full_s | pop_s) & ~(bypass_s & d_ready);

    assign wr_entry_s = '{pc: f_pc, instr: f_instr};

    fetch_buffer_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en_s & reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry_s)
    );

    // Next-state for pointers, occupancy, flush shadow and sticky overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        overflow_d = overflow_q | (push_req_s & full_s & ~pop_s);
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            shadow_d = SH_LOAD;
        end else begin
            if (shadow_q != {SH_W{1'b0}}) begin
                shadow_d = shadow_q - SH_W'(1);
            end else begin
                shadow_d = shadow_q;
            end
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset takes priority over flush and handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            shadow_q   <= {SH_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=4, SKID=2, FLUSH_SHADOW=1).
module tb_fetch_buffer;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        flush;
    logic        stall;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_pc_plus4;
    logic [31:0] d_instr;
    logic        overflow;

    int n_checks;
    int n_errors;

    fetch_buffer #(
        .DEPTH        (4),
        .SKID         (2),
        .FLUSH_SHADOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .f_valid    (f_valid),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .flush      (flush),
        .stall      (stall),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_pc       (d_pc),
        .d_pc_plus4 (d_pc_plus4),
        .d_instr    (d_instr),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        f_valid = v;
        f_pc    = pc;
        f_instr = ins;
    endtask

    logic [31:0] exp_q [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        d_ready  = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check_eq("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);

        // Streaming: d_pc follows 0x0, 0x4, 0x8 one cycle behind each push.
        reset = 1'b1;
        drive(1'b1, 32'h0000_0000, INSTR_NOP);
        tick();
        check_eq("s0_valid", {31'd0, d_valid}, 32'd1);
        check_eq("s0_pc", d_pc, 32'h0000_0000);
        check_eq("s0_pc4", d_pc_plus4, 32'h0000_0004);
        check_eq("s0_instr", d_instr, INSTR_NOP);
        check_eq("s0_stall", {31'd0, stall}, 32'd0);
        d_ready = 1'b1;
        drive(1'b1, 32'h0000_0004, 32'h0040_0093);
        tick();
        check_eq("s1_pc", d_pc, 32'h0000_0004);
        check_eq("s1_pc4", d_pc_plus4, 32'h0000_0008);
        check_eq("s1_instr", d_instr, 32'h0040_0093);
        check_eq("s1_stall", {31'd0, stall}, 32'd0);
        drive(1'b1, 32'h0000_0008, 32'h0080_0113);
        tick();
        check_eq("s2_pc", d_pc, 32'h0000_0008);
        check_eq("s2_pc4", d_pc_plus4, 32'h0000_000C);
        check_eq("s2_stall", {31'd0, stall}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_eq("s3_empty", {31'd0, d_valid}, 32'd0);

        // Fill to full under back-pressure.
        d_ready = 1'b0;
        drive(1'b1, 32'h0000_0010, 32'h0000_1010);
        tick();
        check_eq("f1_stall", {31'd0, stall}, 32'd0);
        drive(1'b1, 32'h0000_0014, 32'h0000_1014);
        tick();
        check_eq("f2_stall", {31'd0, stall}, 32'd1);
        drive(1'b1, 32'h0000_0018, 32'h0000_1018);
        tick();
        check_eq("f3_stall", {31'd0, stall}, 32'd1);
        check_eq("f3_ovf", {31'd0, overflow}, 32'd0);
        drive(1'b1, 32'h0000_001C, 32'h0000_101C);
        tick();
        check_eq("f4_ovf", {31'd0, overflow}, 32'd0);
        check_eq("f4_head", d_pc, 32'h0000_0010);

        // Push+pop at full, then push at full without pop.
        d_ready = 1'b1;
        drive(1'b1, 32'h0000_0020, 32'h0000_1020);
        tick();
        check_eq("fp_head", d_pc, 32'h0000_0014);
        check_eq("fp_stall", {31'd0, stall}, 32'd1);
        check_eq("fp_ovf", {31'd0, overflow}, 32'd0);
        d_ready = 1'b0;
        drive(1'b1, 32'h0000_0024, 32'h0000_1024);
        tick();
        check_eq("ov_set", {31'd0, overflow}, 32'd1);
        check_eq("ov_head", d_pc, 32'h0000_0014);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_eq("ov_sticky", {31'd0, overflow}, 32'd1);
        exp_q[0] = 32'h0000_0014;
        exp_q[1] = 32'h0000_0018;
        exp_q[2] = 32'h0000_001C;
        exp_q[3] = 32'h0000_0020;
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d_pc", i), d_pc, exp_q[i]);
            check_eq($sformatf("drain%0d_instr", i), d_instr, exp_q[i] + 32'h0000_1000);
            tick();
        end
        check_eq("drain_empty", {31'd0, d_valid}, 32'd0);
        check_eq("drain_ovf", {31'd0, overflow}, 32'd1);

        // Flush with three entries held, then shadow drop.
        d_ready = 1'b0;
        drive(1'b1, 32'h0000_0030, 32'h0000_2030);
        tick();
        drive(1'b1, 32'h0000_0034, 32'h0000_2034);
        tick();
        drive(1'b1, 32'h0000_0038, 32'h0000_2038);
        tick();
        check_eq("fl_pre_head", d_pc, 32'h0000_0030);
        check_eq("fl_pre_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 32'h0000_0020, 32'h0000_2020);
        tick();
        flush = 1'b0;
        check_eq("fl_valid", {31'd0, d_valid}, 32'd0);
        check_eq("fl_stall", {31'd0, stall}, 32'd0);
        drive(1'b1, 32'h0000_0024, 32'h0000_2024);
        tick();
        check_eq("sh_drop", {31'd0, d_valid}, 32'd0);
        drive(1'b1, 32'h0000_0080, 32'h0000_2080);
        tick();
        check_eq("sh_after_valid", {31'd0, d_valid}, 32'd1);
        check_eq("sh_after_pc", d_pc, 32'h0000_0080);
        drive(1'b0, 32'h0, 32'h0);
        d_ready = 1'b1;
        tick();
        check_eq("sh_after_empty", {31'd0, d_valid}, 32'd0);

        // Reset wins over flush; reset mid-stream.
        d_ready = 1'b0;
        reset   = 1'b0;
        flush   = 1'b1;
        tick();
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 32'h0000_0090, 32'h0000_3090);
        tick();
        check_eq("rf_valid", {31'd0, d_valid}, 32'd1);
        check_eq("rf_pc", d_pc, 32'h0000_0090);
        check_eq("rf_ovf", {31'd0, overflow}, 32'd0);
        drive(1'b1, 32'h0000_0094, 32'h0000_3094);
        tick();
        drive(1'b1, 32'h0000_0098, 32'h0000_3098);
        tick();
        check_eq("rm_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_eq("rm_valid", {31'd0, d_valid}, 32'd0);
        check_eq("rm_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rm_stall0", {31'd0, stall}, 32'd0);
        reset = 1'b1;
        tick();

        // PC+4 wraps modulo 2^32.
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_4000);
        tick();
        check_eq("wrap_pc", d_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", d_pc_plus4, 32'h0000_0000);
        drive(1'b0, 32'h0, 32'h0);
        d_ready = 1'b1;
        tick();
        check_eq("wrap_empty", {31'd0, d_valid}, 32'd0);

        // Empty buffer, decode ready, single push of 0x40.
        drive(1'b1, 32'h0000_0040, 32'h0000_5040);
        #1;
`ifdef FETCH_BUFFER_BYPASS_EN
        check_eq("bp_same_valid", {31'd0, d_valid}, 32'd1);
        check_eq("bp_same_pc", d_pc, 32'h0000_0040);
        check_eq("bp_same_instr", d_instr, 32'h0000_5040);
`else
        check_eq("nb_same_valid", {31'd0, d_valid}, 32'd0);
`endif
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
`ifdef FETCH_BUFFER_BYPASS_EN
        check_eq("bp_count0", {31'd0, d_valid}, 32'd0);
`else
        check_eq("nb_next_valid", {31'd0, d_valid}, 32'd1);
        check_eq("nb_next_pc", d_pc, 32'h0000_0040);
        check_eq("nb_next_instr", d_instr, 32'h0000_5040);
`endif
        tick();
        check_eq("end_empty", {31'd0, d_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
